// File: rtl/game_flow_fsm.sv
// Game-flow sequencer for whack-a-mole.
// Flow: menu -> timed countdown -> game <-> pause -> over.
// Restart and pause are touch-button regions that must be held before they count.
// The game-controller reset and enable are registered alongside the state.
module game_flow_fsm #(
    parameter int COORD_W         = 16,
    parameter int RST_X0          = 600,
    parameter int RST_Y0          = 400,
    parameter int RST_X1          = 760,
    parameter int RST_Y1          = 470,
    parameter int PSE_X0          = 600,
    parameter int PSE_Y0          = 300,
    parameter int PSE_X1          = 760,
    parameter int PSE_Y1          = 370,
    parameter int TOUCH_HOLD      = 100000,
    parameter int CYCLES_PER_TICK = 50000000,
    parameter int COUNTDOWN_TICKS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               move_on,
    input  logic               tp_valid,
    input  logic [COORD_W-1:0] tp_x_coord,
    input  logic [COORD_W-1:0] tp_y_coord,
    input  logic               game_over,
    output logic [2:0]         state,
    output logic               game_rst_n,
    output logic               game_en,
    output logic [3:0]         countdown,
    output logic [1:0]         over_cause
);

    typedef enum logic [2:0] {
        S_MENU      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_GAME      = 3'd2,
        S_PAUSE     = 3'd3,
        S_OVER      = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_OVER  = 2'd1;
    localparam logic [1:0] CAUSE_ABORT = 2'd2;

    // The hold counter only needs to reach TOUCH_HOLD, where it saturates.
    localparam int HOLD_W = (TOUCH_HOLD > 1) ? $clog2(TOUCH_HOLD + 1) : 1;
    localparam int TICK_W = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;

    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(TOUCH_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(TOUCH_HOLD - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CYCLES_PER_TICK - 1);
    localparam logic [3:0]        CD_LOAD   = 4'(COUNTDOWN_TICKS);

    // Region 0 is restart, region 1 is pause.
    localparam int NUM_REGIONS = 2;
    localparam int REGION_RESTART = 0;
    localparam int REGION_PAUSE   = 1;

    state_t             state_reg, state_next;
    logic [3:0]         countdown_reg, countdown_next;
    logic [1:0]         over_cause_reg, over_cause_next;
    logic [TICK_W-1:0]  tick_reg, tick_next;
    logic               game_rst_n_reg, game_rst_n_next;
    logic               game_en_reg, game_en_next;

    logic [NUM_REGIONS-1:0] press;

    // ------------------------------------------------------------------
    // Touch regions: each has its own hold counter. A press fires once on
    // the edge that completes TOUCH_HOLD consecutive qualifying cycles; the
    // counter then saturates, so it cannot fire again until it is cleared by
    // a non-qualifying cycle.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
            localparam logic [COORD_W-1:0] X0 =
                COORD_W'((gi == REGION_RESTART) ? RST_X0 : PSE_X0);
            localparam logic [COORD_W-1:0] Y0 =
                COORD_W'((gi == REGION_RESTART) ? RST_Y0 : PSE_Y0);
            localparam logic [COORD_W-1:0] X1 =
                COORD_W'((gi == REGION_RESTART) ? RST_X1 : PSE_X1);
            localparam logic [COORD_W-1:0] Y1 =
                COORD_W'((gi == REGION_RESTART) ? RST_Y1 : PSE_Y1);

            logic              qualify;
            logic [HOLD_W-1:0] hold_reg, hold_next;

            // Strict inequalities: the rectangle border itself does not count.
            always_comb begin
                qualify = tp_valid
                          && (tp_x_coord > X0) && (tp_x_coord < X1)
                          && (tp_y_coord > Y0) && (tp_y_coord < Y1);
            end

            // Saturating hold counter, cleared on any non-qualifying cycle.
            always_comb begin
                hold_next = hold_reg;
                if (!qualify) begin
                    hold_next = '0;
                end else if (hold_reg != HOLD_MAX) begin
                    hold_next = hold_reg + 1'b1;
                end
            end

            // Hold counter register.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hold_reg <= '0;
                end else begin
                    hold_reg <= hold_next;
                end
            end

            // Press strobe: the qualifying cycle that completes the hold.
            always_comb begin
                press[gi] = qualify && (hold_reg == HOLD_FIRE);
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state, countdown and cause logic; registered outputs are derived
    // from the next state so they line up with the state register.
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        countdown_next  = countdown_reg;
        over_cause_next = over_cause_reg;
        tick_next       = '0;

        case (state_reg)
            S_MENU: begin
                if (move_on) begin
                    state_next      = S_COUNTDOWN;
                    countdown_next  = CD_LOAD;
                    over_cause_next = CAUSE_NONE;
                end
            end

            S_COUNTDOWN: begin
                if (move_on) begin
                    // Abort back to the menu; the key wins over a tick.
                    state_next     = S_MENU;
                    countdown_next = '0;
                end else if (tick_reg == TICK_LAST) begin
                    if (countdown_reg <= 4'd1) begin
                        state_next     = S_GAME;
                        countdown_next = '0;
                    end else begin
                        countdown_next = countdown_reg - 4'd1;
                    end
                end else begin
                    tick_next = tick_reg + 1'b1;
                end
            end

            S_GAME: begin
                if (game_over) begin
                    state_next      = S_OVER;
                    over_cause_next = CAUSE_OVER;
                end else if (move_on) begin
                    state_next      = S_OVER;
                    over_cause_next = CAUSE_ABORT;
                end else if (press[REGION_RESTART]) begin
                    state_next      = S_COUNTDOWN;
                    countdown_next  = CD_LOAD;
                    over_cause_next = CAUSE_NONE;
                end else if (press[REGION_PAUSE]) begin
                    state_next = S_PAUSE;
                end
            end

            S_PAUSE: begin
                // game_over is deliberately ignored while paused.
                if (press[REGION_RESTART]) begin
                    state_next      = S_COUNTDOWN;
                    countdown_next  = CD_LOAD;
                    over_cause_next = CAUSE_NONE;
                end else if (move_on || press[REGION_PAUSE]) begin
                    state_next = S_GAME;
                end
            end

            S_OVER: begin
                // over_cause is kept for display until the next game starts.
                if (move_on) begin
                    state_next = S_MENU;
                end
            end

            default: begin
                // Unreachable encodings recover to a clean menu.
                state_next      = S_MENU;
                countdown_next  = '0;
                over_cause_next = CAUSE_NONE;
            end
        endcase

        game_rst_n_next = !((state_next == S_MENU) || (state_next == S_COUNTDOWN));
        game_en_next    = (state_next == S_GAME);
    end

    // State and registered output update; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_MENU;
            countdown_reg  <= '0;
            over_cause_reg <= CAUSE_NONE;
            tick_reg       <= '0;
            game_rst_n_reg <= 1'b0;
            game_en_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            countdown_reg  <= countdown_next;
            over_cause_reg <= over_cause_next;
            tick_reg       <= tick_next;
            game_rst_n_reg <= game_rst_n_next;
            game_en_reg    <= game_en_next;
        end
    end

    assign state      = state_reg;
    assign countdown  = countdown_reg;
    assign over_cause = over_cause_reg;
    assign game_rst_n = game_rst_n_reg;
    assign game_en    = game_en_reg;

endmodule

// File: tb/tb_game_flow_fsm.sv
// Directed bench for game_flow_fsm with short tick and hold parameters.
module tb_game_flow_fsm;

    logic        clk;
    logic        rst_n;
    logic        move_on;
    logic        tp_valid;
    logic [15:0] tp_x_coord;
    logic [15:0] tp_y_coord;
    logic        game_over;
    logic [2:0]  state;
    logic        game_rst_n;
    logic        game_en;
    logic [3:0]  countdown;
    logic [1:0]  over_cause;

    int checks   = 0;
    int failures = 0;

    game_flow_fsm #(
        .COORD_W(16),
        .TOUCH_HOLD(3),
        .CYCLES_PER_TICK(4),
        .COUNTDOWN_TICKS(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .move_on(move_on),
        .tp_valid(tp_valid),
        .tp_x_coord(tp_x_coord),
        .tp_y_coord(tp_y_coord),
        .game_over(game_over),
        .state(state),
        .game_rst_n(game_rst_n),
        .game_en(game_en),
        .countdown(countdown),
        .over_cause(over_cause)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 ns before sampling or driving.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_game_rst_n"}, 32'(game_rst_n), 32'd0);
        check({tag, "_game_en"}, 32'(game_en), 32'd0);
        check({tag, "_countdown"}, 32'(countdown), 32'd0);
        check({tag, "_over_cause"}, 32'(over_cause), 32'd0);
    endtask

    task automatic touch(input logic v, input int x, input int y);
        tp_valid   = v;
        tp_x_coord = 16'(x);
        tp_y_coord = 16'(y);
    endtask

    initial begin
        rst_n = 1'b0; move_on = 1'b0; game_over = 1'b0;
        touch(1'b0, 0, 0);

        // Reset state.
        step(2);
        check_reset_values("reset");
        rst_n = 1'b1;
        step(1);
        check("idle_menu", 32'(state), 32'd0);

        // move_on sampled at edge t+1.
        move_on = 1'b1;
        step(1);
        move_on = 1'b0;
        check("cd_enter_state", 32'(state), 32'd1);
        check("cd_enter_count", 32'(countdown), 32'd3);
        check("cd_enter_rst", 32'(game_rst_n), 32'd0);
        step(4);
        check("cd_t5", 32'(countdown), 32'd2);
        step(4);
        check("cd_t9", 32'(countdown), 32'd1);
        step(3);
        check("cd_t12_state", 32'(state), 32'd1);
        step(1);
        check("game_t13_state", 32'(state), 32'd2);
        check("game_t13_rst", 32'(game_rst_n), 32'd1);
        check("game_t13_en", 32'(game_en), 32'd1);
        check("game_t13_cd", 32'(countdown), 32'd0);

        // Touch on the pause rectangle's left edge: not strictly inside.
        touch(1'b1, 600, 330);
        step(4);
        check("edge_no_pause", 32'(state), 32'd2);
        touch(1'b0, 0, 0);
        step(1);

        // Pause press: fires on the third qualifying edge.
        touch(1'b1, 680, 330);
        step(2);
        check("pause_2cyc", 32'(state), 32'd2);
        step(1);
        check("pause_state", 32'(state), 32'd3);
        check("pause_en", 32'(game_en), 32'd0);
        check("pause_rst", 32'(game_rst_n), 32'd1);
        step(5);
        check("pause_held", 32'(state), 32'd3);
        touch(1'b0, 0, 0);
        step(1);
        touch(1'b1, 680, 330);
        step(3);
        check("resume_state", 32'(state), 32'd2);
        check("resume_en", 32'(game_en), 32'd1);
        touch(1'b0, 0, 0);
        step(1);

        // Restart held only 2 + 2 cycles with a release between: no event.
        touch(1'b1, 680, 430);
        step(2);
        touch(1'b0, 0, 0);
        step(1);
        touch(1'b1, 680, 430);
        step(2);
        touch(1'b0, 0, 0);
        step(1);
        check("short_restart", 32'(state), 32'd2);

        // Full restart press.
        touch(1'b1, 680, 430);
        step(3);
        touch(1'b0, 0, 0);
        check("restart_state", 32'(state), 32'd1);
        check("restart_rst", 32'(game_rst_n), 32'd0);
        check("restart_cd", 32'(countdown), 32'd3);
        check("restart_en", 32'(game_en), 32'd0);
        step(11);
        check("restart_11", 32'(state), 32'd1);
        step(1);
        check("restart_12", 32'(state), 32'd2);

        // game_over beats move_on in the same cycle.
        game_over = 1'b1; move_on = 1'b1;
        step(1);
        game_over = 1'b0; move_on = 1'b0;
        check("over_state", 32'(state), 32'd4);
        check("over_cause", 32'(over_cause), 32'd1);
        check("over_en", 32'(game_en), 32'd0);
        check("over_rst", 32'(game_rst_n), 32'd1);
        step(2);
        check("over_hold", 32'(state), 32'd4);
        move_on = 1'b1;
        step(1);
        move_on = 1'b0;
        check("menu_state", 32'(state), 32'd0);
        check("menu_cause_kept", 32'(over_cause), 32'd1);
        check("menu_rst", 32'(game_rst_n), 32'd0);

        // Start again, then reset mid-countdown at countdown=2.
        move_on = 1'b1;
        step(1);
        move_on = 1'b0;
        check("cd2_cause_clr", 32'(over_cause), 32'd0);
        step(4);
        check("cd2_at_2", 32'(countdown), 32'd2);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check_reset_values("midcd_reset");
        step(2);
        check("post_reset_menu", 32'(state), 32'd0);
        move_on = 1'b1;
        step(1);
        move_on = 1'b0;
        check("restart_cd_state", 32'(state), 32'd1);
        check("restart_cd_val", 32'(countdown), 32'd3);

        // Run to GAME and abort with the key: cause 2.
        step(12);
        check("abort_pre_game", 32'(state), 32'd2);
        move_on = 1'b1;
        step(1);
        move_on = 1'b0;
        check("abort_state", 32'(state), 32'd4);
        check("abort_cause", 32'(over_cause), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
